// File: rtl/head_loader_if.sv
// Host command stream into the head loader: 32-bit words with a valid/ready handshake.
interface head_loader_if;
  localparam int unsigned DATA_W = 32;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  // Host side drives words, loader side returns ready.
  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/head_loader.sv
// Parses the host command stream into block-load headers and payload, writes head's
// instruction and weight memories, and owns head's reset (halted while loading).
module head_loader #(
  parameter int unsigned INSTR_AW  = 8,
  parameter int unsigned WEIGHT_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  head_loader_if.slave         cmd,
  output logic                 instr_we,
  output logic [INSTR_AW-1:0]  instr_addr,
  output logic [15:0]          instr_wdata,
  output logic                 weight_we,
  output logic [WEIGHT_AW-1:0] weight_addr,
  output logic [31:0]          weight_wdata,
  output logic                 head_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SUM_W  = 18;

  localparam logic [SUM_W-1:0] INSTR_DEPTH  = SUM_W'(1) << INSTR_AW;
  localparam logic [SUM_W-1:0] WEIGHT_DEPTH = SUM_W'(1) << WEIGHT_AW;

  typedef enum logic [1:0] {
    OP_INSTR  = 2'b00,
    OP_WEIGHT = 2'b01,
    OP_RUN    = 2'b10,
    OP_HALT   = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] base;
  } hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    INSTR_LO,
    INSTR_HI,
    WEIGHT,
    DISCARD
  } state_e;

  state_e              state, state_nx;
  logic [CNT_W-1:0]    rem, rem_nx;
  logic [ADDR_W-1:0]   cur, cur_nx;
  logic [HALF_W-1:0]   hi, hi_nx;

  logic                instr_we_nx;
  logic [INSTR_AW-1:0] instr_addr_nx;
  logic [15:0]         instr_wdata_nx;
  logic                weight_we_nx;
  logic [WEIGHT_AW-1:0] weight_addr_nx;
  logic [31:0]         weight_wdata_nx;
  logic                head_rst_nx;
  logic                busy_nx;
  logic                done_nx;
  logic                err_nx;

  hdr_t                hdr_c;
  logic [SUM_W-1:0]    end_addr_c;
  logic [CNT_W:0]      cnt_p1_c;
  logic [CNT_W-1:0]    instr_words_c;
  logic                range_err_c;
  logic                accept_c;

  // Header decode and range check, evaluated on every word but only used in IDLE.
  assign hdr_c         = hdr_t'(cmd.s_data);
  assign end_addr_c    = SUM_W'(hdr_c.base) + SUM_W'(hdr_c.count);
  assign cnt_p1_c      = (CNT_W+1)'(hdr_c.count) + (CNT_W+1)'(1);
  assign instr_words_c = CNT_W'(cnt_p1_c >> 1);
  assign range_err_c   = (hdr_c.op == OP_INSTR) ? (end_addr_c > INSTR_DEPTH)
                                                : (end_addr_c > WEIGHT_DEPTH);

  // Ready is held low in reset and while the latched high instruction is written.
  assign cmd.s_ready = rst && (state != INSTR_HI);
  assign accept_c    = cmd.s_valid && cmd.s_ready;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rem          <= '0;
      cur          <= '0;
      hi           <= '0;
      instr_we     <= 1'b0;
      instr_addr   <= '0;
      instr_wdata  <= '0;
      weight_we    <= 1'b0;
      weight_addr  <= '0;
      weight_wdata <= '0;
      head_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      rem          <= rem_nx;
      cur          <= cur_nx;
      hi           <= hi_nx;
      instr_we     <= instr_we_nx;
      instr_addr   <= instr_addr_nx;
      instr_wdata  <= instr_wdata_nx;
      weight_we    <= weight_we_nx;
      weight_addr  <= weight_addr_nx;
      weight_wdata <= weight_wdata_nx;
      head_rst     <= head_rst_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      err          <= err_nx;
    end
  end

  // Next-state and next-output logic; rem counts instructions/words still to consume.
  always_comb begin
    state_nx        = state;
    rem_nx          = rem;
    cur_nx          = cur;
    hi_nx           = hi;
    instr_we_nx     = 1'b0;
    instr_addr_nx   = instr_addr;
    instr_wdata_nx  = instr_wdata;
    weight_we_nx    = 1'b0;
    weight_addr_nx  = weight_addr;
    weight_wdata_nx = weight_wdata;
    head_rst_nx     = head_rst;
    done_nx         = 1'b0;
    err_nx          = err;

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          unique case (hdr_c.op)
            OP_INSTR, OP_WEIGHT: begin
              head_rst_nx = 1'b1;
              if (hdr_c.count != '0) begin
                if (range_err_c) begin
                  err_nx   = 1'b1;
                  rem_nx   = (hdr_c.op == OP_INSTR) ? instr_words_c : hdr_c.count;
                  state_nx = DISCARD;
                end else begin
                  rem_nx   = hdr_c.count;
                  cur_nx   = hdr_c.base;
                  state_nx = (hdr_c.op == OP_INSTR) ? INSTR_LO : WEIGHT;
                end
              end
            end
            OP_RUN:  head_rst_nx = 1'b0;
            OP_HALT: head_rst_nx = 1'b1;
            default: head_rst_nx = head_rst;
          endcase
        end
      end

      INSTR_LO: begin
        if (accept_c) begin
          instr_we_nx    = 1'b1;
          instr_addr_nx  = INSTR_AW'(cur);
          instr_wdata_nx = cmd.s_data[HALF_W-1:0];
          hi_nx          = cmd.s_data[WORD_W-1:HALF_W];
          cur_nx         = cur + ADDR_W'(1);
          rem_nx         = rem - CNT_W'(1);
          if (rem > CNT_W'(1)) begin
            state_nx = INSTR_HI;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end

      INSTR_HI: begin
        instr_we_nx    = 1'b1;
        instr_addr_nx  = INSTR_AW'(cur);
        instr_wdata_nx = hi;
        cur_nx         = cur + ADDR_W'(1);
        rem_nx         = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = INSTR_LO;
        end
      end

      WEIGHT: begin
        if (accept_c) begin
          weight_we_nx    = 1'b1;
          weight_addr_nx  = WEIGHT_AW'(cur);
          weight_wdata_nx = cmd.s_data;
          cur_nx          = cur + ADDR_W'(1);
          rem_nx          = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end

      DISCARD: begin
        if (accept_c) begin
          rem_nx = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_nx = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_head_loader.sv
// Self-checking bench for head_loader: directed scenarios plus random command streams,
// compared against a transaction-level model of the command format.
module tb_head_loader;

  localparam int unsigned IAW = 8;
  localparam int unsigned WAW = 4;
  localparam int INSTR_DEPTH  = 1 << IAW;
  localparam int WEIGHT_DEPTH = 1 << WAW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  head_loader_if cmd ();

  logic           instr_we;
  logic [IAW-1:0] instr_addr;
  logic [15:0]    instr_wdata;
  logic           weight_we;
  logic [WAW-1:0] weight_addr;
  logic [31:0]    weight_wdata;
  logic           head_rst, busy, done, err;

  head_loader #(.INSTR_AW(IAW), .WEIGHT_AW(WAW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .instr_we     (instr_we),
    .instr_addr   (instr_addr),
    .instr_wdata  (instr_wdata),
    .weight_we    (weight_we),
    .weight_addr  (weight_addr),
    .weight_wdata (weight_wdata),
    .head_rst     (head_rst),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: one entry per expected memory write, with its due cycle.
  typedef struct {
    bit          is_w;
    int          addr;
    logic [31:0] data;
    int          due;
    bit          last;
  } wr_t;

  wr_t  exp_q[$];
  int   pend_words = 0;
  int   kind       = 0;   // 0 instr, 1 weight, 2 discard
  int   m_addr     = 0;
  int   m_rem      = 0;
  int   hi_cnt     = 0;
  int   rdy_low    = 0;
  logic exp_hr     = 1'b1;
  logic exp_err    = 1'b0;

  task automatic push_wr(input bit is_w, input int addr, input logic [31:0] data,
                         input int due, input bit last);
    wr_t e;
    e.is_w = is_w; e.addr = addr; e.data = data; e.due = due; e.last = last;
    exp_q.push_back(e);
  endtask

  // Apply one accepted word to the model; k is the cycle count just before the accepting edge.
  task automatic model_word(input logic [31:0] w, input int k);
    int op, cnt, base, depth;
    if (pend_words == 0) begin
      op   = int'(w[31:30]);
      cnt  = int'(w[29:16]);
      base = int'(w[15:0]);
      if (op == 2) exp_hr = 1'b0;
      else exp_hr = 1'b1;
      if (op <= 1 && cnt != 0) begin
        depth      = (op == 0) ? INSTR_DEPTH : WEIGHT_DEPTH;
        pend_words = (op == 0) ? (cnt + 1) / 2 : cnt;
        if (base + cnt > depth) begin
          exp_err = 1'b1;
          kind    = 2;
        end else begin
          kind   = op;
          m_addr = base;
          m_rem  = cnt;
        end
      end
    end else begin
      pend_words--;
      if (kind == 0) begin
        push_wr(1'b0, m_addr, {16'h0, w[15:0]}, k + 1, m_rem == 1);
        m_addr++; m_rem--;
        if (m_rem > 0) begin
          push_wr(1'b0, m_addr, {16'h0, w[31:16]}, k + 2, m_rem == 1);
          hi_cnt++; m_addr++; m_rem--;
        end
      end else if (kind == 1) begin
        push_wr(1'b1, m_addr, w, k + 1, pend_words == 0);
        m_addr++;
      end
    end
  endtask

  // Output monitor, sampled just after each active edge.
  initial begin
    wr_t e;
    logic [50:0] o, x;
    bit exp_busy;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset) begin
        if (instr_we || weight_we) begin
          if (exp_q.size() == 0) begin
            check("wr_extra", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            o = {weight_we, instr_we,
                 weight_we ? 16'(weight_addr) : 16'(instr_addr),
                 weight_we ? weight_wdata : {16'h0, instr_wdata}, done};
            x = {e.is_w, ~e.is_w, 16'(e.addr), e.data, e.last};
            check("wr", 64'(o), 64'(x));
            check("wr_cyc", 64'(cyc), 64'(e.due));
          end
        end else begin
          check("done_nowr", 64'(done), 64'(0));
        end
        exp_busy = (pend_words > 0) || (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc);
        check("busy", 64'(busy), 64'(exp_busy));
        check("head_rst", 64'(head_rst), 64'(exp_hr));
        check("err", 64'(err), 64'(exp_err));
        if (!cmd.s_ready) rdy_low++;
      end
    end
  end

  // Present one word after 'gaps' idle cycles and hold it until accepted.
  task automatic send(input logic [31:0] w, input int gaps);
    int  tries = 0;
    bit  ok    = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      cmd.s_valid = 1'b0;
      cmd.s_data  = $urandom;
    end
    while (!ok && tries < 200) begin
      @(negedge clk);
      cmd.s_valid = 1'b1;
      cmd.s_data  = w;
      if (cmd.s_ready) begin
        model_word(w, cyc);
        ok = 1'b1;
      end
      tries++;
    end
    if (!ok) check("send_timeout", 64'(0), 64'(1));
  endtask

  // Let outstanding writes retire and confirm the loader is idle.
  task automatic drain();
    int t = 0;
    @(negedge clk);
    cmd.s_valid = 1'b0;
    while ((exp_q.size() > 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_q", 64'(exp_q.size()), 64'(0));
    check("drain_busy", 64'(busy), 64'(0));
    check("rdy_low", 64'(rdy_low), 64'(hi_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  64'(cmd.s_ready), 64'(0));
    check({tag, "_we"},     64'({instr_we, weight_we}), 64'(0));
    check({tag, "_hr"},     64'(head_rst), 64'(1));
    check({tag, "_flags"},  64'({busy, done, err}), 64'(0));
    check({tag, "_bus"},    64'({instr_addr, instr_wdata, weight_addr}), 64'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_reset = 1'b0;
    #1;
    check("rel_ready", 64'(cmd.s_ready), 64'(1));
  endtask

  initial begin
    int          r, cnt, base, nw, op;
    logic [31:0] hdr;
    logic [31:0] wd;

    cmd.s_valid = 1'b0;
    cmd.s_data  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    release_reset();

    // Instruction load: five instructions packed in three words.
    send(32'h0005_0000, 0);
    send(32'h0002_0001, 0);
    send(32'h0008_0003, 0);
    send(32'h0000_0204, 0);
    drain();

    // Weight load: sixteen words of 1.0.
    send(32'h4010_0000, 0);
    for (int i = 0; i < 16; i++) send(32'h3f80_0000, 0);
    drain();

    // Run, auto-halt on a weight header, explicit halt.
    send(32'h8000_0000, 0);
    send(32'h4001_0003, 0);
    send(32'h4000_0000, 0);
    send(32'hC000_0000, 0);
    drain();

    // Range error: payload discarded, then a normal block; err stays set.
    send(32'h4002_000F, 0);
    send(32'hdead_beef, 0);
    send(32'hcafe_f00d, 0);
    send(32'h4001_0000, 0);
    send(32'h1234_5678, 0);
    drain();

    // Valid gaps inside an odd instruction block, then an empty block.
    send(32'h0003_0010, 0);
    send(32'h1111_2222, 0);
    send(32'h3333_4444, 2);
    drain();
    send(32'h0000_0020, 1);
    @(negedge clk);
    cmd.s_valid = 1'b0;
    check("cnt0_busy", 64'(busy), 64'(0));
    drain();

    // Reset part-way through a weight block, then a fresh block.
    send(32'h4010_0000, 0);
    send(32'haaaa_0001, 0);
    send(32'haaaa_0002, 0);
    @(negedge clk);
    cmd.s_valid = 1'b0;
    rst      = 1'b0;
    in_reset = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    exp_q.delete();
    pend_words = 0;
    exp_hr     = 1'b1;
    exp_err    = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    send(32'h4002_0005, 0);
    send(32'h0bad_f00d, 0);
    send(32'h0000_0042, 1);
    drain();

    // Random command streams with random valid gaps.
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3 || (r >= 4 && r <= 6)) begin
        op  = (r <= 3) ? 0 : 1;
        if (op == 0) begin
          cnt  = int'($urandom_range(1, 12));
          base = int'($urandom_range(0, INSTR_DEPTH - cnt));
          if ($urandom_range(0, 5) == 0) base = INSTR_DEPTH - cnt + int'($urandom_range(1, 40));
          nw = (cnt + 1) / 2;
        end else begin
          cnt  = int'($urandom_range(1, 16));
          base = int'($urandom_range(0, WEIGHT_DEPTH - cnt));
          if ($urandom_range(0, 5) == 0) base = WEIGHT_DEPTH - cnt + int'($urandom_range(1, 40));
          nw = cnt;
        end
        hdr = {2'(op), 14'(cnt), 16'(base)};
        send(hdr, int'($urandom_range(0, 2)));
        for (int i = 0; i < nw; i++) begin
          wd = $urandom;
          send(wd, int'($urandom_range(0, 2)));
        end
      end else if (r == 7) begin
        send(32'h8000_0000 | (32'($urandom) & 32'h3fff_ffff), 0);
      end else if (r == 8) begin
        send(32'hC000_0000 | (32'($urandom) & 32'h3fff_ffff), 0);
      end else begin
        send({2'($urandom_range(0, 1)), 14'h0, 16'($urandom)}, 0);
      end
      if (t % 10 == 9) drain();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d failed so far", n_fail, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
